// File: rtl/stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1_4
// Purpose  : 1-to-4 valid/ready stream demultiplexer. Each accepted input
//            beat is routed to one of four output channels. Every channel has
//            a one-entry register that is either EMPTY or FULL.
//            Latency is 1 cycle. Each channel sustains one beat per cycle.
// Ports    : clk      - clock; all state changes on the rising edge
//            rst      - asynchronous, active-high reset
//            d        - input data beat (WIDTH bits)
//            sel      - destination channel index 0..3
//            d_valid  - input beat present
//            d_ready  - beat accepted this cycle when high with d_valid
//            y0..y3   - registered channel output data (WIDTH bits each)
//            y_valid  - bit i set while channel i holds a beat
//            y_ready  - bit i set when the consumer of channel i takes it
// Options  : STREAM_DEMUX_ROUND_ROBIN_EN - when defined, sel is ignored.
//            Beats are then routed by an internal 2-bit pointer that
//            advances after every accepted beat.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  input  logic [3:0]       y_ready
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  logic [1:0]       route_sel;
  logic             accept;
  logic [3:0]       ch_valid;
  logic [WIDTH-1:0] ch_data [4];

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
  // The pointer selects the destination channel; sel is deliberately unused.
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  assign route_sel = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + 2'd1;  // natural 2-bit wrap 3 -> 0
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign route_sel = sel;
`endif

  // The selected channel can take a beat when it is empty, or when it is
  // being drained in this same cycle. The reset term keeps the input
  // blocked for as long as rst is held.
  assign d_ready = !rst && (!ch_valid[route_sel] || y_ready[route_sel]);
  assign accept  = d_valid && d_ready;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    ch_state_e        state_q;
    ch_state_e        state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load;

    assign load = accept && (route_sel == 2'(i));

    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
        ST_EMPTY: begin
          // y_ready has no effect while the channel is empty.
          if (load) begin
            state_d = ST_FULL;
            data_d  = d;
          end
        end
        ST_FULL: begin
          if (load) begin
            // Drain and refill in the same cycle: no bubble.
            data_d = d;
          end else if (y_ready[i]) begin
            // The data is kept on drain; only the valid flag drops.
            state_d = ST_EMPTY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
      end
    end

    assign ch_valid[i] = (state_q == ST_FULL);
    assign ch_data[i]  = data_q;
  end

  assign y_valid = ch_valid;
  assign y0      = ch_data[0];
  assign y1      = ch_data[1];
  assign y2      = ch_data[2];
  assign y3      = ch_data[3];

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1_4
// Purpose  : Self-checking bench for stream_demux_1_4. It runs directed
//            scenarios followed by randomized traffic. Every channel is
//            modelled as a capacity-1 FIFO that also keeps its last-written
//            value. Define STREAM_DEMUX_ROUND_ROBIN_EN to test that build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_4;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] d;
  logic [1:0]       sel;
  logic             d_valid;
  logic             d_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       y_valid;
  logic [3:0]       y_ready;

  stream_demux_1_4 #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .sel     (sel),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y0      (y0),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the occupancy (0 or 1) and last stored value of each
  // channel, plus the round-robin counter.
  int               m_cnt  [4];
  logic [WIDTH-1:0] m_data [4];
  int               m_rr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] y_of(input int i);
    case (i)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      default: return y3;
    endcase
  endfunction

  function automatic int dest_of(input logic [1:0] s);
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
    return m_rr;
`else
    return int'(s);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_data[i] = '0;
    end
    m_rr = 0;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid%0d", tag, i), 32'(y_valid[i]), 32'(m_cnt[i] != 0));
      check($sformatf("%s_y%0d", tag, i), 32'(y_of(i)), 32'(m_data[i]));
    end
  endtask

  // One clock cycle. It is entered just after a falling edge and returns
  // just after the next falling edge.
  task automatic step(input logic [WIDTH-1:0] dd, input logic [1:0] ss,
                      input logic v, input logic [3:0] yr);
    int   s;
    logic er;
    logic acc;
    d = dd; sel = ss; d_valid = v; y_ready = yr;
    #1;
    s   = dest_of(ss);
    er  = (m_cnt[s] == 0) || yr[s];
    check("d_ready", 32'(d_ready), 32'(er));
    acc = v && er;
    @(posedge clk);
    // The consumer pops first, then the producer pushes (capacity 1).
    for (int i = 0; i < 4; i++) begin
      if (m_cnt[i] > 0 && yr[i]) m_cnt[i]--;
    end
    if (acc) begin
      m_cnt[s]++;
      m_data[s] = dd;
      m_rr = (m_rr + 1) % 4;
    end
    #1;
    check_outputs("out");
    @(negedge clk);
  endtask

  // Raises rst between clock edges, checks that the clear happens
  // immediately, holds rst across one rising edge, then releases it.
  task automatic pulse_reset();
    d_valid = 1'b1; d = 4'hF; y_ready = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check("rst_hold_d_ready", 32'(d_ready), 32'd0);
    check_outputs("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    d_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; d = '0; sel = 2'd0; d_valid = 1'b0; y_ready = 4'b0000;
    model_clear();
    @(negedge clk);
    #1;
    check("init_d_ready", 32'(d_ready), 32'd0);
    check_outputs("init");
    @(negedge clk);
    rst = 1'b0;

`ifndef STREAM_DEMUX_ROUND_ROBIN_EN
    // Single beat to channel 2, drained on the next cycle.
    step(4'hA, 2'd2, 1'b1, 4'b1111);
    check("r027_y2", 32'(y2), 32'hA);
    check("r027_valid", 32'(y_valid), 32'b0100);
    step(4'h0, 2'd0, 1'b0, 4'b1111);
    check("r027_drained", 32'(y_valid), 32'b0000);

    // Backpressure on channel 1.
    step(4'h3, 2'd1, 1'b1, 4'b0000);
    step(4'h5, 2'd1, 1'b1, 4'b0000);
    check("r028_held", 32'(y1), 32'h3);
    step(4'h5, 2'd2, 1'b0, 4'b0000);  // sel may change while stalled
    step(4'h5, 2'd1, 1'b1, 4'b0010);
    check("r028_y1", 32'(y1), 32'h5);
    step(4'h0, 2'd0, 1'b0, 4'b1111);

    // Drain and refill on channel 0 with no bubble.
    step(4'h1, 2'd0, 1'b1, 4'b0000);
    step(4'h7, 2'd0, 1'b1, 4'b0001);
    check("r029_y0", 32'(y0), 32'h7);
    check("r029_valid0", 32'(y_valid[0]), 32'd1);

    // Channel 3 stalls while the others stream.
    step(4'h9, 2'd3, 1'b1, 4'b0000);
    step(4'h2, 2'd0, 1'b1, 4'b0111);
    step(4'h4, 2'd1, 1'b1, 4'b0111);
    step(4'h6, 2'd2, 1'b1, 4'b0111);
    check("r030_y3", 32'(y3), 32'h9);

    // Fill every channel, then reset mid-cycle.
    for (int i = 0; i < 4; i++) step(4'(i + 8), 2'(i), 1'b1, 4'b0000);
    check("r031_all_full", 32'(y_valid), 32'b1111);
    pulse_reset();
`else
    // Round robin: sel is held at 0, yet beats rotate across the channels.
    for (int k = 1; k <= 5; k++) begin
      step(4'(k), 2'd0, 1'b1, 4'b1111);
      check($sformatf("r032_beat%0d", k), 32'(y_of((k - 1) % 4)), 32'(k));
      check($sformatf("r032_valid%0d", k), 32'(y_valid), 32'(1 << ((k - 1) % 4)));
    end
    step(4'h3, 2'd1, 1'b1, 4'b0000);
    step(4'h5, 2'd1, 1'b1, 4'b0000);
    pulse_reset();
`endif

    // Randomized traffic, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset();
      end else begin
        step(4'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
             4'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 SHALL have parameter: WIDTH, 4, data width of input and each output channel.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: d  input  WIDTH  input data beat.
REQ-005 SHALL have port: sel  input  2  destination channel index, 0..3.
REQ-006 SHALL have port: d_valid  input  1  input beat present.
REQ-007 SHALL have port: d_ready  output  1  input beat accepted this cycle when high with d_valid.
REQ-008 SHALL have ports: y0, y1, y2, y3  output  WIDTH each  channel output data, registered.
REQ-009 SHALL have port: y_valid  output  4  bit i = channel i holds a beat.
REQ-010 SHALL have port: y_ready  input  4  bit i = consumer of channel i takes the beat.

Function
REQ-011 SHALL route each accepted beat to exactly one channel, the one selected by sel (y0 for 0 ... y3 for 3), sampled in the accept cycle.
REQ-012 SHALL hold a one-entry register per channel with two states: EMPTY (y_valid[i]=0) and FULL (y_valid[i]=1).
REQ-013 SHALL transition EMPTY->FULL when a beat for channel i is accepted; FULL->EMPTY when y_ready[i]=1 and no new beat for i is accepted; FULL->FULL with new data when both occur in the same cycle.
REQ-014 SHALL drive d_ready = !y_valid[s] | y_ready[s], with s the selected channel; combinational, no dependency on d_valid.
REQ-015 SHALL present an accepted beat on its channel one cycle after acceptance (latency 1), full throughput of one beat per cycle per channel.
REQ-016 SHALL keep yN and y_valid[N] stable while y_valid[N]=1 and y_ready[N]=0.
REQ-017 SHALL leave channels other than the selected one unaffected by input acceptance; their drain proceeds independently on their own y_ready.
REQ-018 SHALL ignore d and sel when d_valid=0; a change of sel while d_valid=1 and d_ready=0 is permitted, and the beat goes to the channel selected in the accept cycle.
REQ-019 SHALL ignore y_ready[i] while channel i is EMPTY.
REQ-020 SHALL not change yN contents when channel N goes FULL->EMPTY (value retained, only y_valid cleared).

Reset
REQ-021 SHALL, on rst=1, immediately set y_valid=4'b0000, y0..y3=0, and internal pointer (REQ-025) to 0, independent of clk.
REQ-022 SHALL discard any held beats when rst asserts mid-operation; no beat is accepted while rst=1 (d_ready=0 during reset).
REQ-023 SHALL accept beats from the first rising edge of clk after rst deasserts.

Configuration
REQ-024 SHALL support macro STREAM_DEMUX_ROUND_ROBIN_EN.
REQ-025 SHALL, with STREAM_DEMUX_ROUND_ROBIN_EN defined, ignore sel and route by an internal 2-bit pointer that starts at 0 and increments by 1 (3 wraps to 0) after each accepted beat; d_ready uses the pointer channel.
REQ-026 SHALL, without STREAM_DEMUX_ROUND_ROBIN_EN, route purely by sel and contain no pointer logic; the sel port exists in both builds.

Verification
REQ-027 SHALL cover: rst=1, then release; d=4'hA, sel=2, d_valid=1, y_ready=4'b1111 -> d_ready=1, next cycle y2=4'hA, y_valid=4'b0100, following cycle y_valid=4'b0000.
REQ-028 SHALL cover backpressure: y_ready=0, two beats 4'h3 then 4'h5 to sel=1 -> first accepted, y1=4'h3 held, d_ready=0 for second until y_ready[1]=1, then y1=4'h5 next cycle.
REQ-029 SHALL cover simultaneous drain and refill: channel 0 FULL with 4'h1, y_ready[0]=1, new beat 4'h7 sel=0 -> d_ready=1, next cycle y0=4'h7, y_valid[0]=1, no bubble.
REQ-030 SHALL cover independence: channel 3 FULL and stalled, beats to sel=0,1,2 with y_ready=4'b0111 -> all accepted back-to-back, y3 unchanged.
REQ-031 SHALL cover reset mid-operation: all channels FULL, rst pulse between clock edges -> y_valid=0 and y0..y3=0 immediately, d_ready=0 during rst.
REQ-032 SHALL cover STREAM_DEMUX_ROUND_ROBIN_EN build: five beats 1..5 with sel held 0, y_ready=4'b1111 -> beats on y0,y1,y2,y3,y0 in order.
